// File: rtl/nexusv_clint.sv
// -----------------------------------------------------------------------------
// nexusv_clint -- core-local interruptor for the nexusV SoC.
//
// A memory-mapped bus slave on the core data bus that holds:
//   * mtime    : 64-bit free-running timer, advanced once every TICK_DIV clocks
//   * mtimecmp : 64-bit compare value; mtip is raised while mtime >= mtimecmp
//   * msip     : single machine software-interrupt bit
//
// Register map (offset from BASE_ADDR, bus_addr[1:0] ignored):
//   0x0000 msip (bit 0), 0x4000/0x4004 mtimecmp lo/hi, 0xBFF8/0xBFFC mtime lo/hi.
//   Other offsets inside the 64 KiB region read 0 and ignore writes, but are
//   still acknowledged. Addresses outside the region get no response at all.
//
// Parameters:
//   BASE_ADDR : region base, region is BASE_ADDR .. BASE_ADDR+0xFFFF
//   TICK_DIV  : clk cycles per mtime increment, legal range 1..65535
//
// Ports:
//   clk        in   clock, all state on the rising edge
//   rst        in   synchronous active-high reset
//   bus_addr   in   byte address from the core
//   bus_wdata  in   write data
//   bus_write  in   1 = write, 0 = read
//   bus_valid  in   request present, held until bus_ready
//   bus_rdata  out  read data, valid while bus_ready is high (0 for writes)
//   bus_ready  out  one-cycle acknowledge, one cycle after the request is taken
//   mtip       out  machine timer interrupt pending (registered compare)
//   msip       out  machine software interrupt pending
// -----------------------------------------------------------------------------
module nexusv_clint #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_write,
    input  logic        bus_valid,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        mtip,
    output logic        msip
);

    // -------------------------------------------------------------------------
    // Register offsets (word aligned)
    // -------------------------------------------------------------------------
    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_MTCMP_LO = 16'h4000;
    localparam logic [15:0] OFF_MTCMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

    localparam logic [15:0] PCNT_LAST    = 16'(TICK_DIV - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state_q;
    logic        bus_ready_q;
    logic [31:0] bus_rdata_q;

    logic [15:0] pcnt_q,     pcnt_d;
    logic [63:0] mtime_q,    mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q,     msip_d;
    logic        mtip_q,     mtip_d;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [31:0] offset;
    logic [15:0] word_off;
    logic        in_region;
    logic        accept;
    logic        wr_en;
    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_time_lo;
    logic        sel_time_hi;
    logic        unused_addr_bits;

    // The subtraction wraps for addresses below BASE_ADDR, which lands them in
    // the upper half of the offset space and so outside the region as well.
    assign offset    = bus_addr - BASE_ADDR;
    assign in_region = (offset[31:16] == 16'h0000);
    assign word_off  = {offset[15:2], 2'b00};

    // Byte lane bits are don't-care for word registers.
    assign unused_addr_bits = ^offset[1:0];

    // A request is taken only in IDLE; RESP ignores bus_valid completely.
    assign accept = (state_q == ST_IDLE) && bus_valid && in_region;
    assign wr_en  = accept && bus_write;

    assign sel_msip    = (word_off == OFF_MSIP);
    assign sel_cmp_lo  = (word_off == OFF_MTCMP_LO);
    assign sel_cmp_hi  = (word_off == OFF_MTCMP_HI);
    assign sel_time_lo = (word_off == OFF_MTIME_LO);
    assign sel_time_hi = (word_off == OFF_MTIME_HI);

    // -------------------------------------------------------------------------
    // Prescaler
    // -------------------------------------------------------------------------
    logic tick;

    assign tick   = (pcnt_q == PCNT_LAST);
    assign pcnt_d = tick ? 16'h0000 : (pcnt_q + 16'h0001);

    // -------------------------------------------------------------------------
    // mtime / mtimecmp next state, one 32-bit word per generate lane.
    // A write to either mtime word suppresses the increment for the whole
    // 64-bit counter that cycle, so the unwritten word keeps its old value
    // instead of picking up a carry.
    // -------------------------------------------------------------------------
    logic [63:0] mtime_inc;
    logic [1:0]  time_wr;
    logic [1:0]  cmp_wr;
    logic        time_wr_any;

    assign mtime_inc   = mtime_q + 64'd1;
    assign time_wr     = {wr_en && sel_time_hi, wr_en && sel_time_lo};
    assign cmp_wr      = {wr_en && sel_cmp_hi,  wr_en && sel_cmp_lo};
    assign time_wr_any = |time_wr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_word
            assign mtime_d[gi*32 +: 32] =
                time_wr[gi] ? bus_wdata :
                time_wr_any ? mtime_q[gi*32 +: 32] :
                tick        ? mtime_inc[gi*32 +: 32] :
                              mtime_q[gi*32 +: 32];

            assign mtimecmp_d[gi*32 +: 32] =
                cmp_wr[gi] ? bus_wdata : mtimecmp_q[gi*32 +: 32];
        end
    endgenerate

    assign msip_d = (wr_en && sel_msip) ? bus_wdata[0] : msip_q;

    // Compare uses pre-edge values, so mtip lags the condition by one cycle.
    assign mtip_d = (mtime_q >= mtimecmp_q);

    // -------------------------------------------------------------------------
    // Read mux (pre-edge register values)
    // -------------------------------------------------------------------------
    logic [31:0] rd_mux;
    logic [31:0] rdata_d;

    always_comb begin
        rd_mux = 32'h0000_0000;
        unique case (1'b1)
            sel_msip:    rd_mux = {31'h0, msip_q};
            sel_cmp_lo:  rd_mux = mtimecmp_q[31:0];
            sel_cmp_hi:  rd_mux = mtimecmp_q[63:32];
            sel_time_lo: rd_mux = mtime_q[31:0];
            sel_time_hi: rd_mux = mtime_q[63:32];
            default:     rd_mux = 32'h0000_0000;
        endcase
    end

    assign rdata_d = (accept && !bus_write) ? rd_mux : 32'h0000_0000;

    // -------------------------------------------------------------------------
    // Slave FSM with registered acknowledge and read data
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_ready_q <= 1'b0;
            bus_rdata_q <= 32'h0000_0000;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_RESP;
                        bus_ready_q <= 1'b1;
                        bus_rdata_q <= rdata_d;
                    end else begin
                        bus_ready_q <= 1'b0;
                        bus_rdata_q <= 32'h0000_0000;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    bus_ready_q <= 1'b0;
                    bus_rdata_q <= 32'h0000_0000;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    bus_ready_q <= 1'b0;
                    bus_rdata_q <= 32'h0000_0000;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Timer and interrupt registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q     <= 16'h0000;
            mtime_q    <= 64'h0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
        end
    end

    assign bus_ready = bus_ready_q;
    assign bus_rdata = bus_rdata_q;
    assign mtip      = mtip_q;
    assign msip      = msip_q;

endmodule

// File: tb/tb_nexusv_clint.sv
// -----------------------------------------------------------------------------
// Directed testbench for nexusv_clint. Two instances share clock and reset:
// u_dut1 with TICK_DIV=1 (most tests) and u_dut4 with TICK_DIV=4 (prescaler).
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_nexusv_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic clk;
    logic rst;

    logic [31:0] a1, wd1, rd1;
    logic        wr1, v1, rdy1, mtip1, msip1;
    logic [31:0] a4, wd4, rd4;
    logic        wr4, v4, rdy4, mtip4, msip4;

    int checks = 0;
    int errors = 0;

    nexusv_clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (a1),
        .bus_wdata (wd1),
        .bus_write (wr1),
        .bus_valid (v1),
        .bus_rdata (rd1),
        .bus_ready (rdy1),
        .mtip      (mtip1),
        .msip      (msip1)
    );

    nexusv_clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (a4),
        .bus_wdata (wd4),
        .bus_write (wr4),
        .bus_valid (v4),
        .bus_rdata (rd4),
        .bus_ready (rdy4),
        .mtip      (mtip4),
        .msip      (msip4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus transaction, called at a falling edge with the slave in IDLE.
    // Returns at a falling edge with the slave back in IDLE (two clocks).
    task automatic access(input bit u4, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic wr, input bit chk, input logic [31:0] exp,
                          input string tag, output logic [31:0] rd,
                          output logic mtip_ack, output logic msip_ack);
        if (u4) begin
            a4 = addr; wd4 = wdata; wr4 = wr; v4 = 1'b1;
        end else begin
            a1 = addr; wd1 = wdata; wr1 = wr; v1 = 1'b1;
        end
        @(negedge clk);
        check({tag, " ready"}, {63'h0, (u4 ? rdy4 : rdy1)}, 64'h1);
        rd       = u4 ? rd4 : rd1;
        mtip_ack = u4 ? mtip4 : mtip1;
        msip_ack = u4 ? msip4 : msip1;
        if (chk) check({tag, " rdata"}, {32'h0, rd}, {32'h0, exp});
        $display("txn %s dut=%0d addr=0x%08h wr=%0d wdata=0x%08h rdata=0x%08h",
                 tag, u4 ? 4 : 1, addr, wr, wdata, rd);
        v1 = 1'b0;
        v4 = 1'b0;
        @(negedge clk);
        check({tag, " ready one cycle"}, {63'h0, (u4 ? rdy4 : rdy1)}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] t_a;
        logic [31:0] t_b;
        logic        mt;
        logic        ms;

        rst = 1'b1;
        a1 = '0; wd1 = '0; wr1 = 1'b0; v1 = 1'b0;
        a4 = '0; wd4 = '0; wr4 = 1'b0; v4 = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("reset ready", {63'h0, rdy1}, 64'h0);
        check("reset rdata", {32'h0, rd1}, 64'h0);
        check("reset mtip",  {63'h0, mtip1}, 64'h0);
        check("reset msip",  {63'h0, msip1}, 64'h0);
        rst = 1'b0;

        // ---- idle 10 cycles, outputs quiet ----
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle ready", {63'h0, rdy1}, 64'h0);
            check("idle mtip",  {63'h0, mtip1}, 64'h0);
            check("idle msip",  {63'h0, msip1}, 64'h0);
        end
        // Ten increments since release; read captures pre-edge value 10.
        access(0, BASE + 32'hBFF8, 32'h0, 1'b0, 1, 32'd10, "mtime lo after idle", rd, mt, ms);

        // ---- prescaler, TICK_DIV=4: 40 clocks apart -> +10 ----
        access(1, BASE + 32'hBFF8, 32'h0, 1'b0, 0, 32'h0, "dut4 mtime first", t_a, mt, ms);
        repeat (38) @(negedge clk);
        access(1, BASE + 32'hBFF8, 32'h0, 1'b0, 0, 32'h0, "dut4 mtime second", t_b, mt, ms);
        check("prescaler delta", {32'h0, t_b - t_a}, 64'd10);

        // ---- mtip rise / fall ----
        access(0, BASE + 32'h4004, 32'h0, 1'b1, 1, 32'h0, "cmp hi=0", rd, mt, ms);
        // mtime := 0x10 at edge P, then 0x10+k after edge P+k.
        access(0, BASE + 32'hBFF8, 32'h10, 1'b1, 1, 32'h0, "mtime lo=0x10", rd, mt, ms);
        access(0, BASE + 32'h4000, 32'h20, 1'b1, 1, 32'h0, "cmp lo=0x20", rd, mt, ms);
        // Now after edge P+3; mtime hits 0x20 after P+16, mtip rises after P+17.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check("mtip still low", {63'h0, mtip1}, 64'h0);
        end
        @(negedge clk);
        check("mtip rise", {63'h0, mtip1}, 64'h1);
        access(0, BASE + 32'h4000, 32'hFFFF_FFFF, 1'b1, 1, 32'h0, "cmp lo=ffffffff", rd, mt, ms);
        check("mtip high during ack", {63'h0, mt}, 64'h1);
        check("mtip fall", {63'h0, mtip1}, 64'h0);
        access(0, BASE + 32'h4000, 32'h0, 1'b0, 1, 32'hFFFF_FFFF, "cmp lo readback", rd, mt, ms);
        access(0, BASE + 32'h4004, 32'h0, 1'b0, 1, 32'h0, "cmp hi readback", rd, mt, ms);

        // ---- msip ----
        access(0, BASE + 32'h0000, 32'h3, 1'b1, 1, 32'h0, "msip write 3", rd, mt, ms);
        check("msip during ack", {63'h0, ms}, 64'h1);
        access(0, BASE + 32'h0000, 32'h0, 1'b0, 1, 32'h1, "msip readback", rd, mt, ms);
        access(0, BASE + 32'h0000, 32'h0, 1'b1, 1, 32'h0, "msip write 0", rd, mt, ms);
        check("msip cleared", {63'h0, ms}, 64'h0);

        // ---- mtime write precedence and low->high carry ----
        // Written at edge R (no increment), read captures at R+2, R+4, R+6.
        access(0, BASE + 32'hBFF8, 32'hFFFF_FFFE, 1'b1, 1, 32'h0, "mtime lo=fffffffe", rd, mt, ms);
        access(0, BASE + 32'hBFF8, 32'h0, 1'b0, 1, 32'hFFFF_FFFF, "mtime lo pre-carry", rd, mt, ms);
        access(0, BASE + 32'hBFFC, 32'h0, 1'b0, 1, 32'h1, "mtime hi carry", rd, mt, ms);
        access(0, BASE + 32'hBFF8, 32'h0, 1'b0, 1, 32'h3, "mtime lo post-carry", rd, mt, ms);

        // ---- out-of-region request gets no response ----
        a1 = BASE + 32'h0001_0000; wd1 = 32'h0; wr1 = 1'b0; v1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("out-of-region read ready", {63'h0, rdy1}, 64'h0);
        end
        wd1 = 32'h1; wr1 = 1'b1;
        repeat (2) @(negedge clk);
        check("out-of-region write ready", {63'h0, rdy1}, 64'h0);
        check("out-of-region write msip", {63'h0, msip1}, 64'h0);
        v1 = 1'b0;
        @(negedge clk);
        access(0, BASE + 32'h0100, 32'h0, 1'b0, 1, 32'h0, "unmapped 0x100", rd, mt, ms);

        // ---- reset while in RESP ----
        a1 = BASE; wd1 = 32'h1; wr1 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        check("pre-reset ready", {63'h0, rdy1}, 64'h1);
        check("pre-reset msip", {63'h0, msip1}, 64'h1);
        rst = 1'b1; v1 = 1'b0;
        @(negedge clk);
        check("reset in RESP ready", {63'h0, rdy1}, 64'h0);
        check("reset in RESP msip", {63'h0, msip1}, 64'h0);
        rst = 1'b0;
        access(0, BASE + 32'hBFF8, 32'h0, 1'b0, 1, 32'h0, "mtime after reset", rd, mt, ms);
        access(0, BASE + 32'h4004, 32'h0, 1'b0, 1, 32'hFFFF_FFFF, "cmp hi after reset", rd, mt, ms);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
